// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit.
// Owns the architectural HI/LO pair and runs mult/multu/div/divu as
// multi-cycle operations; serves mfhi/mflo reads and mthi/mtlo writes.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-low reset
//   MDUOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//           7 mfhi, 8 mflo (9 madd, 10 maddu, 11 msub, 12 msubu when
//           MDU_MADD_EN is defined)
//   Start   launch strobe, honoured only for multi-cycle ops
//   A, B    forwarded rs/rt operands
//   Req     flush of the instruction currently in E
//   Busy    operation in flight (registered)
//   HI, LO  architectural HI/LO
//   MDUOut  HI for mfhi, LO for mflo, else 0 (combinational)
//
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops 9..12).
//
// state | meaning
// IDLE  | accepts launches and mthi/mtlo
// BUSY  | counting down to the HI/LO commit; all writes ignored

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] temp_hi;
  logic [31:0] temp_lo;

  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  logic [31:0] div_b;
  logic [31:0] q_s, r_s, q_u, r_u;

  logic        launch_ok;
  logic [3:0]  launch_cnt;
  logic [63:0] launch_res;

  assign a_s64  = {{32{A[31]}}, A};
  assign b_s64  = {{32{B[31]}}, B};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // A divisor of 1 stands in for both zero (result discarded anyway) and
  // -1 against 0x80000000: A/1 gives exactly the required 0x80000000 rem 0
  // and keeps the signed divider clear of its overflow case.
  assign div_b = ((B == 32'd0) ||
                  ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF))) ? 32'd1 : B;
  assign q_s   = $signed(A) / $signed(div_b);
  assign r_s   = $signed(A) % $signed(div_b);
  assign q_u   = A / div_b;
  assign r_u   = A % div_b;

  always_comb begin
    launch_ok  = 1'b0;
    launch_cnt = 4'(MULT_CYCLES);
    launch_res = {HI, LO};
    case (MDUOp)
      4'd1: begin launch_ok = 1'b1; launch_res = prod_s; end
      4'd2: begin launch_ok = 1'b1; launch_res = prod_u; end
      4'd3: begin
        launch_ok  = 1'b1;
        launch_cnt = 4'(DIV_CYCLES);
        // divide by zero recommits the current HI/LO
        if (B != 32'd0) launch_res = {r_s, q_s};
      end
      4'd4: begin
        launch_ok  = 1'b1;
        launch_cnt = 4'(DIV_CYCLES);
        if (B != 32'd0) launch_res = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      4'd9:  begin launch_ok = 1'b1; launch_res = {HI, LO} + prod_s; end
      4'd10: begin launch_ok = 1'b1; launch_res = {HI, LO} + prod_u; end
      4'd11: begin launch_ok = 1'b1; launch_res = {HI, LO} - prod_s; end
      4'd12: begin launch_ok = 1'b1; launch_res = {HI, LO} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!Req) begin
            if (Start && launch_ok) begin
              temp_hi <= launch_res[63:32];
              temp_lo <= launch_res[31:0];
              cnt     <= launch_cnt;
              state   <= BUSY;
              Busy    <= 1'b1;
            end else if (MDUOp == 4'd5) begin
              HI <= A;
            end else if (MDUOp == 4'd6) begin
              LO <= A;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            HI    <= temp_hi;
            LO    <= temp_lo;
            cnt   <= 4'd0;
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == 4'd7)      MDUOut = HI;
    else if (MDUOp == 4'd8) MDUOut = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written multi-cycle sequences.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  int checks   = 0;
  int failures = 0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    Req = 1'b0; Start = 1'b0;
    MDUOp = 4'd5; A = hi; tick();
    MDUOp = 4'd6; A = lo; tick();
    MDUOp = 4'd0; A = 32'd0;
  endtask

  // Expected result from the arithmetic rules, using 64-bit integers.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] hi,
                                 input logic [31:0] lo, output int n,
                                 output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
`ifdef MDU_MADD_EN
    longint unsigned acc;
    acc = {hi, lo};
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    n = 0; eh = hi; el = lo;
    case (op)
      4'd1: begin n = MC; p = sa * sb; {eh, el} = p; end
      4'd2: begin n = MC; p = ua * ub; {eh, el} = p; end
      4'd3: begin
        n = DC;
        if (b != 32'd0) begin
          q = sa / sb; r = sa - q * sb;
          eh = r[31:0]; el = q[31:0];
        end
      end
      4'd4: begin
        n = DC;
        if (b != 32'd0) begin
          p = ua / ub; eh = 32'(ua % ub); el = p[31:0];
        end
      end
`ifdef MDU_MADD_EN
      4'd9:  begin n = MC; p = acc + longint'(sa * sb); {eh, el} = p; end
      4'd10: begin n = MC; p = acc + ua * ub;           {eh, el} = p; end
      4'd11: begin n = MC; p = acc - longint'(sa * sb); {eh, el} = p; end
      4'd12: begin n = MC; p = acc - ua * ub;           {eh, el} = p; end
`endif
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pre_hi, input logic [31:0] pre_lo, input int n,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int cnt;
    write_hilo(pre_hi, pre_lo);
    MDUOp = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
    cnt = 0;
    while (Busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check($sformatf("%s busy_cycles", name), 32'(cnt), 32'(n));
    check($sformatf("%s HI", name), HI, eh);
    check($sformatf("%s LO", name), LO, el);
    MDUOp = 4'd7; #1;
    check($sformatf("%s mfhi", name), MDUOut, eh);
    MDUOp = 4'd8; #1;
    check($sformatf("%s mflo", name), MDUOut, el);
    MDUOp = 4'd0;
  endtask

  initial begin
    vecs[0]  = '{4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1x2"};
    vecs[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, MC, 32'h0000_0001, 32'hFFFF_FFFE, "multu_maxx2"};
    vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
    vecs[3]  = '{4'd4, 32'd7, 32'd0, 32'h11, 32'h22, DC, 32'h11, 32'h22, "divu_by0"};
    vecs[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd6, DC, 32'd0, 32'h8000_0000, "div_ovf"};
    vecs[5]  = '{4'd3, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, DC, 32'd1, 32'hFFFF_FFFD, "div_7_m2"};
    vecs[6]  = '{4'd4, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0, DC, 32'd5, 32'h1999_9999, "divu_max_10"};
    vecs[7]  = '{4'd3, 32'd5, 32'd0, 32'hAA, 32'hBB, DC, 32'hAA, 32'hBB, "div_by0"};
    vecs[8]  = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, MC, 32'h4000_0000, 32'd0, "mult_min_min"};
`ifdef MDU_MADD_EN
    vecs[9]  = '{4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, MC, 32'd1, 32'd0, "maddu_carry"};
`else
    vecs[9]  = '{4'd10, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 32'd0, 32'hFFFF_FFFF, "maddu_absent"};
`endif
    vecs[10] = '{4'd0, 32'd3, 32'd4, 32'h33, 32'h44, 0, 32'h33, 32'h44, "start_op0"};

    reset = 1'b0; MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0; Req = 1'b0;
    tick(); tick();
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pre_hi, vecs[i].pre_lo,
            vecs[i].n, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b, ph, pl, eh, el;
      int          n, k;
      k  = int'($urandom_range(7, 0));
      op = (k < 4) ? 4'(k + 1) : 4'(k + 5);
      a  = $urandom; b = $urandom; ph = $urandom; pl = $urandom;
      if ($urandom_range(7, 0) == 0) b = 32'd0;
      if ($urandom_range(7, 0) == 0) a = 32'h8000_0000;
      if ($urandom_range(7, 0) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(3, 0) == 0) b = 32'($urandom_range(15, 1));
      ref_op(op, a, b, ph, pl, n, eh, el);
      do_op(op, a, b, ph, pl, n, eh, el, $sformatf("rand%0d_op%0d", i, op));
    end

    // reset in the middle of a div discards it
    write_hilo(32'h99, 32'h77);
    MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1; tick();
    Start = 1'b0; MDUOp = 4'd0; tick(); tick();
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    check("midreset Busy", {31'd0, Busy}, 32'd0);
    check("midreset HI", HI, 32'd0);
    check("midreset LO", LO, 32'd0);
    MDUOp = 4'd7; #1;
    check("midreset mfhi", MDUOut, 32'd0);
    MDUOp = 4'd0;
    for (int i = 0; i < DC; i++) tick();
    check("midreset no resume Busy", {31'd0, Busy}, 32'd0);
    check("midreset no resume LO", LO, 32'd0);

    // mthi/mtlo suppressed by Req
    write_hilo(32'h55, 32'h66);
    MDUOp = 4'd5; A = 32'h1234; Req = 1'b1; tick();
    MDUOp = 4'd6; tick();
    Req = 1'b0; MDUOp = 4'd0;
    check("mthi Req HI", HI, 32'h55);
    check("mtlo Req LO", LO, 32'h66);
    MDUOp = 4'd5; A = 32'h1234; tick();
    MDUOp = 4'd7; #1;
    check("mthi HI", HI, 32'h1234);
    check("mthi mfhi", MDUOut, 32'h1234);
    MDUOp = 4'd0; #1;
    check("op0 MDUOut", MDUOut, 32'd0);
    MDUOp = 4'd9; #1;
`ifndef MDU_MADD_EN
    check("op9 MDUOut", MDUOut, 32'd0);
`endif
    MDUOp = 4'd0;

    // Req during BUSY does not cancel; Start, mthi while BUSY ignored
    write_hilo(32'd0, 32'd0);
    MDUOp = 4'd1; A = 32'd3; B = 32'd4; Start = 1'b1; tick();        // now t+1
    Start = 1'b0; MDUOp = 4'd0; tick();                              // t+2
    Req = 1'b1; tick();                                              // t+3
    Req = 1'b0; MDUOp = 4'd3; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();                                                          // t+4
    Start = 1'b0; MDUOp = 4'd5; A = 32'hDEAD; tick();                // t+5
    MDUOp = 4'd8; #1;
    check("inflight Busy t+5", {31'd0, Busy}, 32'd1);
    check("inflight old LO", MDUOut, 32'd0);
    MDUOp = 4'd0; tick();                                            // t+6
    check("inflight Busy t+6", {31'd0, Busy}, 32'd0);
    check("inflight HI", HI, 32'd0);
    check("inflight LO", LO, 32'd12);
    tick();
    check("second start ignored Busy", {31'd0, Busy}, 32'd0);
    check("second start ignored LO", LO, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit of the E stage; sits beside the E-stage ALU and takes the same forwarded A/B operands.
- Owns the architectural HI/LO registers and runs mult/multu/div/divu as multi-cycle operations.
- Raises Busy so the hazard unit stalls D-stage MDU instructions.
- Serves mfhi/mflo reads combinationally and takes mthi/mtlo writes. Results flow to the E/M register alongside ALUOut.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (range 1..15)
- DIV_CYCLES, 10, Busy duration for div/divu (range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears state)
- MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
- Start  in  1  launch strobe; honoured only with MDUOp 1..4
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- Req  in  1  exception/interrupt flush of the instruction currently in E
- Busy  out  1  operation in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- MDUOut  out  32  HI if MDUOp==7, LO if MDUOp==8, else 0 (combinational)

Behaviour:
- Reset: HI=0, LO=0, Busy=0, state IDLE, counter 0. Reset has priority over everything, including mid-operation: a pending result is discarded.
- States: IDLE, BUSY. Busy = (state==BUSY), registered. No combinational path from Start to Busy.
- Launch: in IDLE with Start=1, MDUOp in 1..4 and Req=0:
  - result latched into internal tempHI/tempLO at that edge;
  - counter ← MULT_CYCLES or DIV_CYCLES;
  - state ← BUSY.
- BUSY, each edge:
  - counter==1: HI←tempHI, LO←tempLO, state←IDLE;
  - otherwise counter decrements.
- Timing for Start in cycle t: Busy=1 in cycles t+1..t+N; new HI/LO visible from cycle t+N+1; Busy=0 in cycle t+N+1.
- Start while BUSY: ignored; the in-flight op is unaffected. The stall logic must prevent this case; the block must not corrupt state if it occurs.
- Req=1: Start, mthi and mtlo in the same cycle have no effect. An operation already in BUSY is not cancelled and completes normally (the instruction has already passed E).
- mthi/mtlo (Req=0, IDLE): HI←A or LO←A at the edge, visible the next cycle. While BUSY they are ignored.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: same, unsigned.
  - div: LO = truncated quotient, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div/divu, B==0): operation still runs the full DIV_CYCLES with Busy; HI/LO keep their previous values at completion.
- MDUOut reflects current HI/LO, including during BUSY (old values). The stall unit must hold mfhi/mflo while Busy.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MDUOp 9 madd, 10 maddu, 11 msub, 12 msubu become valid Start ops.
  - Each takes MULT_CYCLES.
  - Result {HI,LO} ± product (signed or unsigned product), computed at launch against the HI/LO values in place at launch, 64-bit wrap-around.
- Not defined: codes 9..12 behave as op 0 (no launch, MDUOut=0). No madd logic is synthesised.

Test Plan:
- Reset held low 2 cycles during an active div → Busy=0, HI=LO=0 the next cycle; an mfhi read returns 0.
- mult A=0xFFFFFFFF, B=2, Start in cycle t → Busy high t+1..t+5; from t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with HI=0x11, LO=0x22 preloaded → Busy 10 cycles, then HI=0x11, LO=0x22.
- mthi A=0x1234 with Req=1 → HI unchanged. Repeated with Req=0 → HI=0x1234 next cycle; mfhi drives MDUOut=0x1234.
- Start mult, then Req=1 on cycle t+2 and a second Start div on t+3 → first result committed at t+6, second Start ignored, Busy drops at t+6.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0 after 5 Busy cycles. Without the macro the same op leaves Busy=0 and HI/LO unchanged.
